pulse_period_meter: RTL and testbench
=====================================

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the period and high-time counters and outputs (legal 4..32).
REQ-002 Parameter SYNC_STAGES, default 2, number of input synchronizer flops (legal >= 2).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  measurement enable; low forces IDLE.
REQ-006 sig_in  input  1  asynchronous periodic signal under measurement.
REQ-007 period  output  WIDTH  last measured period, clk cycles, rising edge to rising edge.
REQ-008 high_time  output  WIDTH  last measured high duration, clk cycles, within that period.
REQ-009 period_valid  output  1  single-cycle pulse; period/high_time updated this cycle.
REQ-010 timeout  output  1  single-cycle pulse; no rising edge within 2^WIDTH-1 cycles.
REQ-011 busy  output  1  high in ARM or MEASURE.

Function
REQ-012 sig_in shall pass through SYNC_STAGES flops then one edge-history flop; sync = last synchronizer stage, rise = sync & ~history.
REQ-013 Detection latency: a sig_in rising edge stable before clock edge N shall produce rise at cycle N+SYNC_STAGES.
REQ-014 FSM states IDLE, ARM, MEASURE; enable=0 from any state -> IDLE next cycle, counters cleared.
REQ-015 IDLE, enable=1 -> ARM next cycle.
REQ-016 ARM, rise=1 -> MEASURE; cnt<=1, hcnt<=1; no period_valid (first edge only starts measurement).
REQ-017 MEASURE, rise=0: cnt<=cnt+1; hcnt<=hcnt+sync.
REQ-018 MEASURE, rise=1: period<=cnt, high_time<=hcnt, period_valid<=1 next cycle, cnt<=1, hcnt<=1, remain MEASURE.
REQ-019 Result: square wave of P cycles with H high cycles yields period=P, high_time=H from second detected edge onward.
REQ-020 MEASURE, rise=0 and cnt=2^WIDTH-1: timeout pulse next cycle, state -> ARM, cnt/hcnt cleared, period/high_time unchanged.
REQ-021 Simultaneous rise and cnt=2^WIDTH-1: rise wins; period=2^WIDTH-1 reported valid, no timeout.
REQ-022 hcnt shall never exceed cnt; no counter shall wrap.
REQ-023 period and high_time hold last valid values through IDLE, ARM, timeout; change only with period_valid.
REQ-024 period_valid and timeout shall never both be high in one cycle.
REQ-025 busy registered: 1 in ARM/MEASURE, 0 in IDLE.

Reset
REQ-026 reset=1 at a clock edge: state IDLE; period, high_time, cnt, hcnt = 0; period_valid, timeout, busy = 0; synchronizer and history flops = 0.
REQ-027 reset takes priority over enable and rise; mid-MEASURE reset discards partial measurement, no period_valid or timeout.
REQ-028 After reset release with enable=1, first period_valid requires two detected rising edges.

Verification
REQ-029 WIDTH=16, enable=1, sig_in square P=10, H=4 -> first edge no pulse; each later edge period_valid with period=10, high_time=4.
REQ-030 sig_in toggling every clk (P=2, H=1) -> period=2, high_time=1 on every valid pulse.
REQ-031 WIDTH=8, one rising edge then sig_in held high -> timeout exactly 255 cycles after rise, state ARM, period/high_time unchanged.
REQ-032 WIDTH=8, edges exactly 255 cycles apart -> period_valid with period=255, no timeout.
REQ-033 reset asserted 5 cycles into a P=20 measurement -> all outputs 0; after release, no period_valid until two new edges, then period=20.
REQ-034 enable dropped mid-measurement then raised -> busy 0 in IDLE, outputs hold prior values, next valid needs two fresh edges.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Pulse period meter.
// Synchronizes an asynchronous periodic input and measures its period
// (rising edge to rising edge) and its high time within that period, both in
// clk cycles. A result is published with a one-cycle period_valid pulse. If
// no rising edge arrives within the counter range, a one-cycle timeout pulse
// is raised and the meter re-arms for a fresh first edge.
module pulse_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             period_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   history;
    logic                   sync;
    logic                   rise;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] hcnt_next;
    logic [WIDTH-1:0] period_next;
    logic [WIDTH-1:0] high_time_next;
    logic             period_valid_next;
    logic             timeout_next;

    assign sync = sync_ff[SYNC_STAGES-1];
    assign rise = sync & ~history;

    // Input synchronizer chain followed by one edge-history flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
            history <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage capture its
            // predecessor's old value; blocking ones would collapse the chain.
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
            history <= sync;
        end
    end

    // Next-state and datapath decisions for the measurement FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // leaves one unassigned and no latch is inferred.
        state_next        = state;
        cnt_next          = cnt;
        hcnt_next         = hcnt;
        period_next       = period;
        high_time_next    = high_time;
        period_valid_next = 1'b0;
        timeout_next      = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            hcnt_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ARM;
                end
                ARM: begin
                    // The first edge only opens the measurement window.
                    if (rise) begin
                        state_next = MEASURE;
                        cnt_next   = CNT_ONE;
                        hcnt_next  = CNT_ONE;
                    end
                end
                MEASURE: begin
                    // A rising edge takes priority over the timeout check, so
                    // a period of exactly CNT_MAX is still reported.
                    if (rise) begin
                        period_next       = cnt;
                        high_time_next    = hcnt;
                        period_valid_next = 1'b1;
                        cnt_next          = CNT_ONE;
                        hcnt_next         = CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        timeout_next = 1'b1;
                        state_next   = ARM;
                        cnt_next     = '0;
                        hcnt_next    = '0;
                    end else begin
                        cnt_next  = cnt + CNT_ONE;
                        hcnt_next = hcnt + {{(WIDTH-1){1'b0}}, sync};
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    hcnt_next  = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            hcnt         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            hcnt         <= hcnt_next;
            period       <= period_next;
            high_time    <= high_time_next;
            period_valid <= period_valid_next;
            timeout      <= timeout_next;
            busy         <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter.
// A reference model works on absolute edge indices: it recovers detected
// rising edges from the recorded sig_in/reset history and derives period and
// high time by subtraction and summation over the measurement window.
module tb_pulse_period_meter;

    localparam int WIDTH = 8;
    localparam int SS    = 2;
    localparam int MAX   = (1 << WIDTH) - 1;
    localparam int HMAX  = 16384;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             period_valid;
    logic             timeout;
    logic             busy;

    pulse_period_meter #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sig_in      (sig_in),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int g     = 0;

    bit hist_sig[HMAX];
    bit hist_rst[HMAX];

    typedef enum {M_OFF, M_ARMED, M_MEAS} mode_t;
    mode_t mode   = M_OFF;
    int    t0     = 0;
    int    exp_per = 0;
    int    exp_hi  = 0;
    bit    exp_valid;
    bit    exp_to;

    // Synchronized view of the sample taken at edge j: zero if any reset hit
    // the chain while that sample was travelling through it.
    function automatic bit eff(input int j);
        if (j < 0) return 1'b0;
        if (!hist_sig[j]) return 1'b0;
        for (int k = j; k < j + SS; k++) begin
            if (hist_rst[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one clock edge, advance the reference model, score all outputs.
    task automatic step(input bit r, input bit en, input bit s);
        bit rise_m;
        int hsum;
        if (g >= HMAX) begin
            $display("FAIL cycle_budget: edge index %0d reached limit %0d", g, HMAX);
            $fatal(1);
        end
        reset  = r;
        enable = en;
        sig_in = s;
        @(posedge clk);
        #1;
        rise_m    = eff(g - SS) && !eff(g - SS - 1);
        exp_valid = 1'b0;
        exp_to    = 1'b0;
        if (r) begin
            mode    = M_OFF;
            exp_per = 0;
            exp_hi  = 0;
        end else if (!en) begin
            mode = M_OFF;
        end else begin
            case (mode)
                M_OFF:   mode = M_ARMED;
                M_ARMED: if (rise_m) begin
                    mode = M_MEAS;
                    t0   = g;
                end
                M_MEAS: begin
                    if (rise_m) begin
                        exp_per = g - t0;
                        hsum    = 0;
                        for (int j = t0 - SS; j < g - SS; j++) hsum += int'(eff(j));
                        exp_hi    = hsum;
                        exp_valid = 1'b1;
                        t0        = g;
                    end else if (g - t0 == MAX) begin
                        exp_to = 1'b1;
                        mode   = M_ARMED;
                    end
                end
                default: mode = M_OFF;
            endcase
        end
        hist_sig[g] = s;
        hist_rst[g] = r;

        tests++;
        if (period_valid !== exp_valid) begin
            fails++;
            $display("FAIL model_period_valid edge=%0d got=%b exp=%b", g, period_valid, exp_valid);
        end
        tests++;
        if (timeout !== exp_to) begin
            fails++;
            $display("FAIL model_timeout edge=%0d got=%b exp=%b", g, timeout, exp_to);
        end
        tests++;
        if (period !== WIDTH'(exp_per)) begin
            fails++;
            $display("FAIL model_period edge=%0d got=%0d exp=%0d", g, period, exp_per);
        end
        tests++;
        if (high_time !== WIDTH'(exp_hi)) begin
            fails++;
            $display("FAIL model_high_time edge=%0d got=%0d exp=%0d", g, high_time, exp_hi);
        end
        tests++;
        if (busy !== (mode != M_OFF)) begin
            fails++;
            $display("FAIL model_busy edge=%0d got=%b exp=%b", g, busy, (mode != M_OFF));
        end
        g++;
    endtask

    // Drop enable, then re-arm with sig_in low so the next rise is clean.
    task automatic clean_start();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'($urandom % 2));
            tests++;
            if ({period, high_time, period_valid, timeout, busy} !== '0) begin
                fails++;
                $display("FAIL reset_outputs got=%0h/%0h/%b/%b/%b exp=all zero",
                         period, high_time, period_valid, timeout, busy);
            end
        end
        step(1'b0, 1'b1, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_busy got=%b exp=1", busy);
        end
    endtask

    task automatic test_square(input int p, input int h, input int nper);
        int n_valid = 0;
        clean_start();
        for (int k = 0; k < nper + 1; k++) begin
            for (int c = 0; c < p; c++) begin
                // The extra final period is held low so only nper edges occur.
                step(1'b0, 1'b1, (k < nper) && (c < h));
                if (period_valid === 1'b1) begin
                    n_valid++;
                    tests++;
                    if (period !== WIDTH'(p) || high_time !== WIDTH'(h)) begin
                        fails++;
                        $display("FAIL square_value P=%0d H=%0d got=%0d/%0d exp=%0d/%0d",
                                 p, h, period, high_time, p, h);
                    end
                end
            end
        end
        tests++;
        if (n_valid != nper - 1) begin
            fails++;
            $display("FAIL square_count P=%0d H=%0d got=%0d exp=%0d", p, h, n_valid, nper - 1);
        end
    endtask

    task automatic test_timeout();
        logic [WIDTH-1:0] per_before;
        logic [WIDTH-1:0] hi_before;
        int gi;
        int to_count = 0;
        int to_at    = -1;
        int n_valid  = 0;
        clean_start();
        per_before = period;
        hi_before  = high_time;
        gi = g;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (timeout === 1'b1) begin
                to_count++;
                to_at = (g - 1) - gi;
            end
            if (period_valid === 1'b1) n_valid++;
        end
        tests++;
        if (to_count != 1 || to_at != SS + MAX) begin
            fails++;
            $display("FAIL timeout_timing got count=%0d offset=%0d exp count=1 offset=%0d",
                     to_count, to_at, SS + MAX);
        end
        tests++;
        if (period !== per_before || high_time !== hi_before || n_valid != 0) begin
            fails++;
            $display("FAIL timeout_hold got=%0d/%0d valids=%0d exp=%0d/%0d valids=0",
                     period, high_time, n_valid, per_before, hi_before);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL timeout_rearm_busy got=%b exp=1", busy);
        end
    endtask

    task automatic test_max_period(input int gap);
        int n_valid  = 0;
        int n_to     = 0;
        int exp_nv   = (gap <= MAX) ? 2 : 0;
        int exp_nt   = (gap <= MAX) ? 0 : 2;
        clean_start();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < gap; c++) begin
                step(1'b0, 1'b1, (c < 3) && !(k == 2 && c >= 3));
                if (timeout === 1'b1) n_to++;
                if (period_valid === 1'b1) begin
                    n_valid++;
                    tests++;
                    if (period !== WIDTH'(gap) || high_time !== WIDTH'(3)) begin
                        fails++;
                        $display("FAIL max_period_value gap=%0d got=%0d/%0d exp=%0d/3",
                                 gap, period, high_time, gap);
                    end
                end
            end
        end
        tests++;
        if (n_valid != exp_nv || n_to != exp_nt) begin
            fails++;
            $display("FAIL max_period_count gap=%0d got valids=%0d timeouts=%0d exp %0d/%0d",
                     gap, n_valid, n_to, exp_nv, exp_nt);
        end
    endtask

    task automatic test_reset_mid();
        int n_valid = 0;
        clean_start();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 20; c++) step(1'b0, 1'b1, c < 4);
        for (int c = 0; c < 7; c++) step(1'b0, 1'b1, c < 4);
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({period, high_time, period_valid, timeout, busy} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs got=%0h/%0h/%b/%b/%b exp=all zero",
                     period, high_time, period_valid, timeout, busy);
        end
        for (int c = 8; c < 20; c++) begin
            step(1'b0, 1'b1, 1'b0);
            if (period_valid === 1'b1) n_valid++;
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 20; c++) begin
                step(1'b0, 1'b1, (k < 3) && (c < 4));
                if (period_valid === 1'b1) begin
                    n_valid++;
                    tests++;
                    if (period !== WIDTH'(20) || high_time !== WIDTH'(4)) begin
                        fails++;
                        $display("FAIL reset_mid_value got=%0d/%0d exp=20/4", period, high_time);
                    end
                end
            end
        end
        tests++;
        if (n_valid != 2) begin
            fails++;
            $display("FAIL reset_mid_count got=%0d exp=2", n_valid);
        end
    endtask

    task automatic test_enable_drop();
        int n_valid = 0;
        clean_start();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 12; c++) step(1'b0, 1'b1, c < 5);
        for (int c = 0; c < 12; c++) begin
            step(1'b0, !(c >= 6 && c < 10), c < 5);
            if (c >= 6 && c < 10) begin
                tests++;
                if (busy !== 1'b0 || period !== WIDTH'(12) || high_time !== WIDTH'(5)
                    || period_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL enable_drop_idle got busy=%b out=%0d/%0d valid=%b exp busy=0 out=12/5 valid=0",
                             busy, period, high_time, period_valid);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 12; c++) begin
                step(1'b0, 1'b1, (k < 3) && (c < 5));
                if (period_valid === 1'b1) begin
                    n_valid++;
                    tests++;
                    if (period !== WIDTH'(12) || high_time !== WIDTH'(5)) begin
                        fails++;
                        $display("FAIL enable_drop_value got=%0d/%0d exp=12/5", period, high_time);
                    end
                end
            end
        end
        tests++;
        if (n_valid != 2) begin
            fails++;
            $display("FAIL enable_drop_count got=%0d exp=2", n_valid);
        end
    endtask

    task automatic test_random();
        bit level = 1'b0;
        bit en    = 1'b1;
        int left  = 0;
        clean_start();
        for (int i = 0; i < 2500; i++) begin
            if (left == 0) begin
                level = ~level;
                left  = ($urandom % 8 == 0) ? $urandom_range(200, 300) : $urandom_range(1, 20);
            end
            left--;
            if (en && ($urandom % 80 == 0)) en = 1'b0;
            else if (!en && ($urandom % 4 == 0)) en = 1'b1;
            step(($urandom % 500 == 0), en, level);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        test_reset();
        test_square(10, 4, 8);
        test_square(2, 1, 10);
        for (int i = 0; i < 4; i++) begin
            int p;
            p = $urandom_range(3, 40);
            test_square(p, $urandom_range(1, p - 1), 6);
        end
        test_timeout();
        test_max_period(MAX);
        test_max_period(MAX + 1);
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(HMAX * 10 * 2);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
